// File: rtl/cache_refill_controller.sv
// -----------------------------------------------------------------------------
// cache_refill_controller
//
// Single-clock controller for a direct-mapped cache. An accepted request is
// looked up, refilled word by word from main memory on a miss, and finally
// read out of the cache.
//
// Optional feature macro: CACHE_STATS_EN
//   Defined     -> hit_count / miss_count ports and saturating counters exist.
//   Not defined -> those ports and counters are absent; all other behaviour
//                  is identical.
//
// Output decode is derived from the state register, so clear_n forces every
// output to its idle value at once without waiting for a clock edge.
// cache_write is the one exception: it follows mem_ready in the same cycle so
// the returning word can be written without an extra buffer stage.
// -----------------------------------------------------------------------------
module cache_refill_controller #(
  parameter int ADDR_W = 15,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16,
  localparam int OFS_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] address,
  input  logic              hit,
  input  logic              mem_ready,
  output logic              ready,
  output logic              cache_read,
  output logic              cache_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OFS_W-1:0]  word_sel
`ifdef CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
`endif
);

  // State encoding kept as plain constants so it matches older netlists.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOOKUP  = 2'd1;
  localparam logic [1:0] ST_REFILL  = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  // Last word offset of a block; the refill stops here instead of wrapping.
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(WORDS - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [OFS_W-1:0]  cnt_r;
  logic [OFS_W-1:0]  cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;

  // Next-state, refill-counter and address-latch logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    addr_nxt_s  = addr_r;
    case (state_r)
      ST_IDLE: begin
        // Only IDLE samples req, so a request held high during a refill
        // cannot disturb the address being serviced.
        if (req) begin
          addr_nxt_s  = address;
          state_nxt_s = ST_LOOKUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          state_nxt_s = ST_RESPOND;
        end else begin
          cnt_nxt_s   = {OFS_W{1'b0}};
          state_nxt_s = ST_REFILL;
        end
      end
      ST_REFILL: begin
        // Stalls with everything held until memory returns a word.
        if (mem_ready) begin
          if (cnt_r == LAST_OFS) begin
            state_nxt_s = ST_RESPOND;
          end else begin
            cnt_nxt_s = cnt_r + OFS_W'(1);
          end
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end
      ST_RESPOND: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        // Unreachable encodings recover to a safe idle state.
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {OFS_W{1'b0}};
      end
    endcase
  end

  // State, counter and latched-address registers with asynchronous clear.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {OFS_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  // Output decode from the current state; all outputs default to zero.
  always_comb begin
    ready       = 1'b0;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    mem_read    = 1'b0;
    mem_addr    = {ADDR_W{1'b0}};
    word_sel    = {OFS_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_LOOKUP: begin
        ready = 1'b0;
      end
      ST_REFILL: begin
        mem_read    = 1'b1;
        mem_addr    = {addr_r[ADDR_W-1:OFS_W], cnt_r};
        word_sel    = cnt_r;
        cache_write = mem_ready;
      end
      ST_RESPOND: begin
        cache_read = 1'b1;
        word_sel   = addr_r[OFS_W-1:0];
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Hit/miss statistics, updated once per lookup.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_LOOKUP) begin
      if (hit) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end else begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
    end else begin
      hit_cnt_r  <= hit_cnt_r;
      miss_cnt_r <= miss_cnt_r;
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_controller
//
// Directed bench. Each cycle the expected output vector is pushed to a
// scoreboard queue before the inputs are driven; it is popped and compared
// 1 time unit after the falling clock edge, well away from the rising edge.
// Statistics checks are compiled only when CACHE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_cache_refill_controller;

  logic        clk;
  logic        clear_n;
  logic        req;
  logic [14:0] address;
  logic        hit;
  logic        mem_ready;
  logic        ready;
  logic        cache_read;
  logic        cache_write;
  logic        mem_read;
  logic [14:0] mem_addr;
  logic [1:0]  word_sel;
`ifdef CACHE_STATS_EN
  logic [1:0]  hit_count;
  logic [1:0]  miss_count;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [20:0] exp_q[$];
  string       tag_q[$];

  cache_refill_controller #(
    .ADDR_W(15),
    .WORDS (4),
    .CNT_W (2)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .req        (req),
    .address    (address),
    .hit        (hit),
    .mem_ready  (mem_ready),
    .ready      (ready),
    .cache_read (cache_read),
    .cache_write(cache_write),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .word_sel   (word_sel)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {ready, cache_read, cache_write, mem_read, mem_addr, word_sel}
  task automatic push(input string t, input logic r, input logic cr, input logic cw,
                      input logic mr, input logic [14:0] ma, input logic [1:0] ws);
    exp_q.push_back({r, cr, cw, mr, ma, ws});
    tag_q.push_back(t);
  endtask

  task automatic push_idle(input string t);
    push(t, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0000, 2'd0);
  endtask

  task automatic push_zero(input string t);
    push(t, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000, 2'd0);
  endtask

  task automatic check_now();
    logic [20:0] o;
    logic [20:0] e;
    string       t;
    o = {ready, cache_read, cache_write, mem_read, mem_addr, word_sel};
    e = 'x;
    t = "scoreboard_underflow";
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
    end
    total++;
    assert (o === e) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic check_val(input string t, input int o, input int e);
    total++;
    assert (o === e) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", t, o, e);
    end
  endtask

  task automatic cyc(input logic rq, input logic [14:0] a, input logic h, input logic mr);
    @(negedge clk);
    req       = rq;
    address   = a;
    hit       = h;
    mem_ready = mr;
    #1;
    check_now();
  endtask

  // Hit transaction: IDLE accepts, LOOKUP with hit, RESPOND reads the word.
  task automatic run_hit(input string t, input logic [14:0] a);
    push_idle({t, "_idle"});
    cyc(1'b1, a, 1'b0, 1'b0);
    push_zero({t, "_lookup"});
    cyc(1'b0, 15'h0000, 1'b1, 1'b0);
    push({t, "_respond"}, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, a[1:0]);
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
  endtask

  // Miss transaction with mem_ready held high: four back-to-back refill words.
  task automatic run_miss(input string t, input logic [14:0] a);
    logic [14:0] base;
    base = {a[14:2], 2'b00};
    push_idle({t, "_idle"});
    cyc(1'b1, a, 1'b0, 1'b1);
    push_zero({t, "_lookup"});
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push({t, "_refill"}, 1'b0, 1'b0, 1'b1, 1'b1, base + 15'(i), 2'(i));
      cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    end
    push({t, "_respond"}, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, a[1:0]);
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    int wcnt;
    logic mr;
    clear_n   = 1'b0;
    req       = 1'b0;
    address   = 15'h0000;
    hit       = 1'b0;
    mem_ready = 1'b0;

    // Reset state before any clock edge.
    #1;
    push_idle("reset_state");
    check_now();
    @(negedge clk);
    clear_n = 1'b1;

    // Hit on 0x1234: lookup, read word 0, ready again; mem_read stays low.
    run_hit("hit_1234", 15'h1234);
    push_idle("hit_1234_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);

    // Spurious mem_ready while idle changes nothing.
    push_idle("idle_mem_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push_idle("idle_mem_ready_after");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);

    // Miss on 0x00A6 with mem_ready held: explicit refill addresses.
    push_idle("miss_a6_c0");
    cyc(1'b1, 15'h00A6, 1'b0, 1'b1);
    push_zero("miss_a6_c1_lookup");
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push("miss_a6_c2", 1'b0, 1'b0, 1'b1, 1'b1, 15'h00A4, 2'd0);
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push("miss_a6_c3", 1'b0, 1'b0, 1'b1, 1'b1, 15'h00A5, 2'd1);
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push("miss_a6_c4", 1'b0, 1'b0, 1'b1, 1'b1, 15'h00A6, 2'd2);
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push("miss_a6_c5", 1'b0, 1'b0, 1'b1, 1'b1, 15'h00A7, 2'd3);
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push("miss_a6_c6_respond", 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 2'd2);
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push_idle("miss_a6_c7_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);

    // Miss on 0x0153 with mem_ready every third cycle: hold between pulses.
    push_idle("slow_idle");
    cyc(1'b1, 15'h0153, 1'b0, 1'b0);
    push_zero("slow_lookup");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
    wcnt = 0;
    for (int k = 0; k < 12; k++) begin
      mr = ((k % 3) == 2);
      push("slow_refill", 1'b0, 1'b0, mr, 1'b1, 15'h0150 + 15'(k / 3), 2'(k / 3));
      cyc(1'b0, 15'h0000, 1'b0, mr);
      if (cache_write === 1'b1) wcnt++;
    end
    push("slow_respond", 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 2'd3);
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
    if (cache_write === 1'b1) wcnt++;
    check_val("slow_write_pulses", wcnt, 4);
    push_idle("slow_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);

    // Reset during refill after the second word: outputs drop with no edge.
    push_idle("abort_idle");
    cyc(1'b1, 15'h2C01, 1'b0, 1'b0);
    push_zero("abort_lookup");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
    push("abort_w0", 1'b0, 1'b0, 1'b1, 1'b1, 15'h2C00, 2'd0);
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push("abort_w1", 1'b0, 1'b0, 1'b1, 1'b1, 15'h2C01, 2'd1);
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    push("abort_wait", 1'b0, 1'b0, 1'b0, 1'b1, 15'h2C02, 2'd2);
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
    #1;
    clear_n = 1'b0;
    #1;
    push_idle("abort_async_clear");
    check_now();
    @(negedge clk);
    clear_n = 1'b1;
    run_hit("after_abort", 15'h0007);
    push_idle("after_abort_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);

    // req held high with address changing mid-refill: latched address stays.
    push_idle("hold_idle");
    cyc(1'b1, 15'h0A5A, 1'b0, 1'b0);
    push_zero("hold_lookup");
    cyc(1'b1, 15'h7FFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push("hold_refill", 1'b0, 1'b0, 1'b1, 1'b1, 15'h0A58 + 15'(i), 2'(i));
      cyc(1'b1, 15'h1111 + 15'(i), 1'b0, 1'b1);
    end
    push("hold_respond", 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 2'd2);
    cyc(1'b1, 15'h3333, 1'b0, 1'b0);
    push_idle("hold_new_idle");
    cyc(1'b1, 15'h0001, 1'b0, 1'b0);
    push_zero("hold_new_lookup");
    cyc(1'b0, 15'h0000, 1'b1, 1'b0);
    push("hold_new_respond", 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 2'd1);
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
    push_idle("hold_new_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);

`ifdef CACHE_STATS_EN
    // Statistics: clear, 5 hits and 1 miss with 2-bit saturating counters.
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    check_val("stats_reset_hits", int'(hit_count), 0);
    check_val("stats_reset_misses", int'(miss_count), 0);
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_hit("stats_hit", 15'h0100 + 15'(i));
      push_idle("stats_spurious_mr");
      cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    end
    run_miss("stats_miss", 15'h0042);
    push_idle("stats_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b1);
    check_val("stats_hits_saturated", int'(hit_count), 3);
    check_val("stats_misses", int'(miss_count), 1);
`else
    // Without statistics, exercise the shared miss helper once more.
    run_miss("plain_miss", 15'h0042);
    push_idle("plain_ready");
    cyc(1'b0, 15'h0000, 1'b0, 1'b0);
`endif

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_refill_controller.md
CACHE_REFILL_CONTROLLER -- requirements
Module: cache_refill_controller

Interface
REQ-001 Parameter ADDR_W, default 15: word-address width.
REQ-002 Parameter WORDS, default 4: words per cache block; power of two, at least 2; OFS_W = log2(WORDS).
REQ-003 Parameter CNT_W, default 16: statistics counter width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port clear_n, input, 1: reset; asynchronous, active-low.
REQ-006 Port req, input, 1: processor access request, sampled only in IDLE.
REQ-007 Port address, input, ADDR_W: processor word address, captured with req.
REQ-008 Port hit, input, 1: cache tag-match result for the captured address, sampled in LOOKUP.
REQ-009 Port mem_ready, input, 1: main memory returns one refill word this cycle.
REQ-010 Port ready, output, 1: controller idle; a new request can be accepted.
REQ-011 Port cache_read, output, 1: read the cache word at word_sel.
REQ-012 Port cache_write, output, 1: write the memory word into the cache at word_sel.
REQ-013 Port mem_read, output, 1: refill read request to main memory.
REQ-014 Port mem_addr, output, ADDR_W: main memory word address.
REQ-015 Port word_sel, output, OFS_W: word offset within the block.
REQ-016 Ports hit_count and miss_count, output, CNT_W each: statistics; present only under REQ-032.

Function
REQ-017 FSM states: IDLE, LOOKUP, REFILL, RESPOND.
REQ-018 In IDLE: ready=1. If req=1, latch address and go to LOOKUP; otherwise stay in IDLE.
REQ-019 In LOOKUP: if hit=1, go to RESPOND; otherwise clear the refill counter to 0 and go to REFILL.
REQ-020 In REFILL: mem_read=1; mem_addr = {latched address[ADDR_W-1:OFS_W], counter}; word_sel = counter.
REQ-021 In REFILL, when mem_ready=1: assert cache_write combinationally in the same cycle.
REQ-022 On the same edge, if counter = WORDS-1, go to RESPOND; otherwise increment the counter.
REQ-023 In REFILL, when mem_ready=0: hold state, counter and outputs.
REQ-024 In RESPOND: cache_read=1; word_sel = latched address[OFS_W-1:0]; next state is IDLE.
REQ-025 Outside their asserting states: ready, cache_read, cache_write and mem_read are 0, and mem_addr and word_sel are 0.
REQ-026 Latency on hit: req in cycle 0, LOOKUP in cycle 1, cache_read in cycle 2, ready in cycle 3.
REQ-027 Latency on miss: 2 + (cycles to collect WORDS mem_ready pulses) + 1 cycles from req to ready.
REQ-028 req outside IDLE is ignored, and the latched address is not changed.
REQ-029 mem_ready outside REFILL is ignored.
REQ-030 The refill counter never wraps beyond WORDS-1 within one refill.

Reset
REQ-031 On clear_n=0, immediately and regardless of clk:
- state goes to IDLE; counter and latched address go to 0;
- ready=1; all other outputs are 0, including the statistics counters;
- a refill in progress is abandoned with mem_read dropped at once;
- operation resumes on the first clk edge after clear_n returns to 1.

Configuration
REQ-032 Macro CACHE_STATS_EN enables the statistics counters.
- Defined: hit_count increments on each LOOKUP with hit=1; miss_count increments on each LOOKUP with hit=0.
- Both counters saturate at all-ones and never wrap.
- Not defined: both ports and their counters are absent, and function is otherwise identical.

Verification
REQ-033 Reset, then req=1 with address=0x1234 and hit=1 -> LOOKUP in cycle 1, cache_read=1 with word_sel=0 in cycle 2, ready=1 in cycle 3; mem_read never asserted.
REQ-034 WORDS=4, address=0x00A6, hit=0, mem_ready held at 1 -> mem_addr 0x00A4, 0x00A5, 0x00A6, 0x00A7 on consecutive cycles, each with cache_write=1; then cache_read with word_sel=2; ready on cycle 7.
REQ-035 Miss with mem_ready pulsed every third cycle -> counter and mem_addr hold between pulses; exactly 4 cache_write pulses occur.
REQ-036 clear_n driven low after the second refill word -> mem_read=0 and ready=1 without a clock edge; the next request restarts from LOOKUP.
REQ-037 req held at 1 continuously while address changes mid-refill -> the latched address is unchanged; a new lookup starts only from IDLE.
REQ-038 With CACHE_STATS_EN and CNT_W=2: 5 hits and 1 miss -> hit_count=3 (saturated) and miss_count=1; spurious mem_ready in IDLE has no effect.
